// File: rtl/apu_shared_arbiter.sv
// apu_shared_arbiter
//
// Shares one auxiliary processing unit (FPU / DSP-mult / int-div cluster)
// between NCORES core-side request ports.
//
// Each cycle one pending request is picked by round-robin and forwarded to
// the APU. Every accepted operation records its issuing core in an in-order
// tag FIFO. APU results return in issue order, so the FIFO head always names
// the core that owns the current result.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   core_req_i       per-core request
//   core_gnt_o       per-core grant, one-hot or zero
//   core_op_i        per-core opcode, core c at [c*WOP +: WOP]
//   core_operands_i  per-core operands, core c at [c*NARGS*WIDTH +: NARGS*WIDTH]
//   core_flags_i     per-core downstream flags, core c at [c*NDSFLAGS +: NDSFLAGS]
//   core_rvalid_o    per-core result valid, one-hot or zero
//   core_result_o    APU result, broadcast to all cores
//   core_rflags_o    APU result flags, broadcast to all cores
//   apu_req_o        request to the shared APU
//   apu_gnt_i        APU accepts the request
//   apu_op_o         opcode of the selected core
//   apu_operands_o   operands of the selected core
//   apu_flags_o      flags of the selected core
//   apu_rvalid_i     APU result valid
//   apu_result_i     APU result
//   apu_rflags_i     APU result flags
//   busy_o           tag FIFO non-empty (registered)
//   err_o            sticky error: a result arrived with nothing outstanding
module apu_shared_arbiter #(
  parameter int NCORES          = 4,
  parameter int NARGS           = 3,
  parameter int WOP             = 6,
  parameter int NDSFLAGS        = 15,
  parameter int NUSFLAGS        = 5,
  parameter int WIDTH           = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NCORES-1:0]               core_req_i,
  output logic [NCORES-1:0]               core_gnt_o,
  input  logic [NCORES*WOP-1:0]           core_op_i,
  input  logic [NCORES*NARGS*WIDTH-1:0]   core_operands_i,
  input  logic [NCORES*NDSFLAGS-1:0]      core_flags_i,
  output logic [NCORES-1:0]               core_rvalid_o,
  output logic [WIDTH-1:0]                core_result_o,
  output logic [NUSFLAGS-1:0]             core_rflags_o,
  output logic                            apu_req_o,
  input  logic                            apu_gnt_i,
  output logic [WOP-1:0]                  apu_op_o,
  output logic [NARGS*WIDTH-1:0]          apu_operands_o,
  output logic [NDSFLAGS-1:0]             apu_flags_o,
  input  logic                            apu_rvalid_i,
  input  logic [WIDTH-1:0]                apu_result_i,
  input  logic [NUSFLAGS-1:0]             apu_rflags_i,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int CW  = $clog2(NCORES);
  localparam int AW  = $clog2(MAX_OUTSTANDING);
  localparam int OPW = NARGS * WIDTH;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] SEL_ONE  = CW'(1);
  localparam logic [CW-1:0] SEL_LAST = CW'(NCORES - 1);

  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              busy;
  logic              err;

  logic [NCORES-1:0] req_vec;
  logic [CW-1:0]     sel;
  logic              sel_valid;
  logic [CW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              pop;

  // Requests are masked while reset is held so the issue-side outputs show
  // their idle values even if cores keep requesting through a reset.
  assign req_vec    = rst ? '0 : core_req_i;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];

  // A full FIFO blocks issue outright; a pop in the same cycle does not
  // free the slot until the following cycle.
  assign apu_req_o  = sel_valid && !fifo_full;
  assign accept     = apu_req_o && apu_gnt_i;

  // A result with nothing outstanding is never attributed to the op being
  // granted in the same cycle; it is dropped and flagged instead.
  assign pop        = apu_rvalid_i && !fifo_empty;

  assign core_result_o = apu_result_i;
  assign core_rflags_o = apu_rflags_i;
  assign busy_o        = busy;
  assign err_o         = err;

  // Round-robin pick: scan cores starting at rr_ptr and wrap modulo NCORES.
  // The inner loop keeps every bit-select index constant.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NCORES) idx = idx - NCORES;
      for (int c = 0; c < NCORES; c++) begin
        if (!sel_valid && (c == idx) && req_vec[c]) begin
          sel       = CW'(c);
          sel_valid = 1'b1;
        end
      end
    end
  end

  // Forward the selected core's operation and decode grant and result-valid
  // strobes. All of these outputs are zero when idle.
  always_comb begin
    apu_op_o       = '0;
    apu_operands_o = '0;
    apu_flags_o    = '0;
    core_gnt_o     = '0;
    core_rvalid_o  = '0;
    for (int c = 0; c < NCORES; c++) begin
      if (sel_valid && (sel == CW'(c))) begin
        apu_op_o       = core_op_i[c*WOP +: WOP];
        apu_operands_o = core_operands_i[c*OPW +: OPW];
        apu_flags_o    = core_flags_i[c*NDSFLAGS +: NDSFLAGS];
      end
      core_gnt_o[c]    = accept && (sel == CW'(c));
      core_rvalid_o[c] = pop && (head == CW'(c));
    end
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_next = count;
    if (accept && !pop)      count_next = count + CNT_ONE;
    else if (!accept && pop) count_next = count - CNT_ONE;
  end

  // Tag FIFO, round-robin pointer, busy and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + PTR_ONE;
        rr_ptr          <= (sel == SEL_LAST) ? '0 : sel + SEL_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (apu_rvalid_i && fifo_empty) err <= 1'b1;
      count <= count_next;
      busy  <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_apu_shared_arbiter.sv
// tb_apu_shared_arbiter
//
// Directed bench for apu_shared_arbiter with the default parameters
// (4 cores, 3 x 32-bit operands, 6-bit opcode, 15/5-bit flags, depth 4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 unit later, registered state 1 unit after the next edge.
module tb_apu_shared_arbiter;

  localparam int NCORES   = 4;
  localparam int NARGS    = 3;
  localparam int WOP      = 6;
  localparam int NDSFLAGS = 15;
  localparam int NUSFLAGS = 5;
  localparam int WIDTH    = 32;
  localparam int MAXOUT   = 4;

  logic                          clk;
  logic                          rst;
  logic [NCORES-1:0]             core_req_i;
  logic [NCORES-1:0]             core_gnt_o;
  logic [NCORES*WOP-1:0]         core_op_i;
  logic [NCORES*NARGS*WIDTH-1:0] core_operands_i;
  logic [NCORES*NDSFLAGS-1:0]    core_flags_i;
  logic [NCORES-1:0]             core_rvalid_o;
  logic [WIDTH-1:0]              core_result_o;
  logic [NUSFLAGS-1:0]           core_rflags_o;
  logic                          apu_req_o;
  logic                          apu_gnt_i;
  logic [WOP-1:0]                apu_op_o;
  logic [NARGS*WIDTH-1:0]        apu_operands_o;
  logic [NDSFLAGS-1:0]           apu_flags_o;
  logic                          apu_rvalid_i;
  logic [WIDTH-1:0]              apu_result_i;
  logic [NUSFLAGS-1:0]           apu_rflags_i;
  logic                          busy_o;
  logic                          err_o;

  int num_checks = 0;
  int num_fail   = 0;

  apu_shared_arbiter #(
    .NCORES(NCORES), .NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDSFLAGS),
    .NUSFLAGS(NUSFLAGS), .WIDTH(WIDTH), .MAX_OUTSTANDING(MAXOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_op_i(core_op_i), .core_operands_i(core_operands_i),
    .core_flags_i(core_flags_i), .core_rvalid_o(core_rvalid_o),
    .core_result_o(core_result_o), .core_rflags_o(core_rflags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_op_o(apu_op_o),
    .apu_operands_o(apu_operands_o), .apu_flags_o(apu_flags_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
    .apu_rflags_i(apu_rflags_i), .busy_o(busy_o), .err_o(err_o)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NCORES-1:0] req, input logic gnt,
                               input logic rvalid);
    core_req_i   = req;
    apu_gnt_i    = gnt;
    apu_rvalid_i = rvalid;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    rst          = 1'b1;
    core_req_i   = '0;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Operand a of core c is 0xA000_0000 + 16*c + a.
  function automatic logic [NARGS*WIDTH-1:0] core_operands(input int c);
    logic [NARGS*WIDTH-1:0] r;
    for (int a = 0; a < NARGS; a++) r[a*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(c*16 + a);
    return r;
  endfunction

  logic [NCORES-1:0] resp_exp [3];

  initial begin
    rst          = 1'b1;
    core_req_i   = '0;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    apu_result_i = 32'h1234_5678;
    apu_rflags_i = 5'h0A;
    for (int c = 0; c < NCORES; c++) begin
      core_op_i[c*WOP +: WOP]                     = 6'h10 + 6'(c);
      core_operands_i[c*NARGS*WIDTH +: NARGS*WIDTH] = core_operands(c);
      core_flags_i[c*NDSFLAGS +: NDSFLAGS]        = 15'h100 + 15'(c);
    end
    step();
    step();

    $display("[TB] reset values");
    checkOutput("rst_gnt", core_gnt_o, 4'b0000);
    checkOutput("rst_rvalid", core_rvalid_o, 4'b0000);
    checkOutput("rst_apu_req", apu_req_o, 1'b0);
    checkOutput("rst_apu_op", apu_op_o, 6'h00);
    checkOutput("rst_apu_operands", apu_operands_o, 96'h0);
    checkOutput("rst_apu_flags", apu_flags_o, 15'h0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_result_pass", core_result_o, 32'h1234_5678);
    checkOutput("rst_rflags_pass", core_rflags_o, 5'h0A);
    rst = 1'b0;

    $display("[TB] single request from core 2");
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("c2_gnt", core_gnt_o, 4'b0100);
    checkOutput("c2_apu_req", apu_req_o, 1'b1);
    checkOutput("c2_apu_op", apu_op_o, 6'h12);
    checkOutput("c2_apu_operands", apu_operands_o, 96'hA0000022_A0000021_A0000020);
    checkOutput("c2_apu_flags", apu_flags_o, 15'h102);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("c2_rr_ptr", dut.rr_ptr, 2'd3);
    checkOutput("c2_busy", busy_o, 1'b1);
    checkOutput("c2_idle_op", apu_op_o, 6'h00);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("c2_rvalid", core_rvalid_o, 4'b0100);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("c2_busy_clear", busy_o, 1'b0);
    checkOutput("c2_err", err_o, 1'b0);

    $display("[TB] round-robin, all cores requesting");
    applyReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 1'b1, k > 0);
      checkOutput("rr_gnt", core_gnt_o, 4'b0001 << (k % 4));
      checkOutput("rr_rvalid", core_rvalid_o, (k > 0) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000);
      step();
    end
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("rr_last_rvalid", core_rvalid_o, 4'b1000);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("rr_count", dut.count, 3'd0);
    checkOutput("rr_err", err_o, 1'b0);

    $display("[TB] full FIFO stall");
    applyReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput("full_fill_gnt", core_gnt_o, 4'b0001 << k);
      step();
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("full_apu_req", apu_req_o, 1'b0);
    checkOutput("full_gnt", core_gnt_o, 4'b0000);
    checkOutput("full_count", dut.count, 3'd4);
    checkOutput("full_busy", busy_o, 1'b1);
    step();
    checkOutput("full_hold_apu_req", apu_req_o, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("full_pop_rvalid", core_rvalid_o, 4'b0001);
    checkOutput("full_no_bypass_gnt", core_gnt_o, 4'b0000);
    checkOutput("full_no_bypass_req", apu_req_o, 1'b0);
    step();
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("full_resume_req", apu_req_o, 1'b1);
    checkOutput("full_resume_gnt", core_gnt_o, 4'b0001);
    checkOutput("full_resume_count", dut.count, 3'd3);
    step();

    $display("[TB] routed responses 3,1,3");
    applyReset();
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("route_gnt0", core_gnt_o, 4'b1000);
    step();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("route_gnt1", core_gnt_o, 4'b0010);
    step();
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("route_gnt2", core_gnt_o, 4'b1000);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("route_count", dut.count, 3'd3);
    apu_result_i = 32'hDEAD_BEEF;
    apu_rflags_i = 5'h11;
    resp_exp[0]  = 4'b1000;
    resp_exp[1]  = 4'b0010;
    resp_exp[2]  = 4'b1000;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("route_rvalid", core_rvalid_o, resp_exp[r]);
      checkOutput("route_result", core_result_o, 32'hDEAD_BEEF);
      checkOutput("route_rflags", core_rflags_o, 5'h11);
      step();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("route_gap_rvalid", core_rvalid_o, 4'b0000);
      step();
    end
    checkOutput("route_busy", busy_o, 1'b0);
    checkOutput("route_err", err_o, 1'b0);

    $display("[TB] push and pop together at count 2");
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("pp_gnt0", core_gnt_o, 4'b0001);
    step();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("pp_gnt1", core_gnt_o, 4'b0010);
    step();
    applyStimulus(4'b0100, 1'b1, 1'b1);
    checkOutput("pp_gnt2", core_gnt_o, 4'b0100);
    checkOutput("pp_rvalid", core_rvalid_o, 4'b0001);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("pp_count", dut.count, 3'd2);
    checkOutput("pp_err", err_o, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("pp_drain0", core_rvalid_o, 4'b0010);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("pp_drain1", core_rvalid_o, 4'b0100);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("pp_empty", dut.count, 3'd0);

    $display("[TB] response with empty FIFO");
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("empty_rvalid", core_rvalid_o, 4'b0000);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("empty_err", err_o, 1'b1);
    step();
    checkOutput("empty_err_sticky", err_o, 1'b1);
    applyStimulus(4'b0001, 1'b1, 1'b1);
    checkOutput("empty_push_gnt", core_gnt_o, 4'b0001);
    checkOutput("empty_push_rvalid", core_rvalid_o, 4'b0000);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("empty_push_count", dut.count, 3'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("empty_push_rvalid2", core_rvalid_o, 4'b0001);
    step();

    $display("[TB] reset with 3 outstanding");
    applyStimulus(4'b0111, 1'b1, 1'b0);
    checkOutput("mid_gnt0", core_gnt_o, 4'b0010);
    step();
    checkOutput("mid_gnt1", core_gnt_o, 4'b0100);
    step();
    checkOutput("mid_gnt2", core_gnt_o, 4'b0001);
    step();
    checkOutput("mid_count", dut.count, 3'd3);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_gnt", core_gnt_o, 4'b0000);
    checkOutput("mid_rst_apu_req", apu_req_o, 1'b0);
    checkOutput("mid_rst_apu_op", apu_op_o, 6'h00);
    checkOutput("mid_rst_operands", apu_operands_o, 96'h0);
    checkOutput("mid_rst_flags", apu_flags_o, 15'h0);
    checkOutput("mid_rst_rvalid", core_rvalid_o, 4'b0000);
    checkOutput("mid_rst_busy", busy_o, 1'b0);
    checkOutput("mid_rst_err", err_o, 1'b0);
    checkOutput("mid_rst_count", dut.count, 3'd0);
    step();
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("post_rst_rvalid", core_rvalid_o, 4'b0000);
    step();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("post_rst_err", err_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/apu_shared_arbiter.md
# apu_shared_arbiter

Shares one auxiliary processing unit (FPU / DSP-mult / int-div cluster) between several core-side APU request ports. Each cycle it selects one pending request by round-robin and forwards it to the shared APU. It records the issuing core of every accepted operation in an in-order tag FIFO, and routes each APU result back to the core that issued it. The block sits between the core APU interfaces and the cluster-level shared APU.

## Interface
Parameters:
- NCORES, 4, number of requesting cores (2..8)
- NARGS, 3, operands per operation
- WOP, 6, opcode width
- NDSFLAGS, 15, downstream (core->APU) flag width
- NUSFLAGS, 5, upstream (APU->core) flag width
- WIDTH, 32, operand/result width
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- core_req_i  in  NCORES  per-core request
- core_gnt_o  out  NCORES  per-core grant, one-hot or zero
- core_op_i  in  NCORES*WOP  per-core opcode, core c at [c*WOP +: WOP]
- core_operands_i  in  NCORES*NARGS*WIDTH  per-core operands
- core_flags_i  in  NCORES*NDSFLAGS  per-core downstream flags
- core_rvalid_o  out  NCORES  per-core result valid, one-hot or zero
- core_result_o  out  WIDTH  result, broadcast to all cores
- core_rflags_o  out  NUSFLAGS  result flags, broadcast
- apu_req_o  out  1  request to shared APU
- apu_gnt_i  in  1  APU accepts request
- apu_op_o  out  WOP  selected opcode
- apu_operands_o  out  NARGS*WIDTH  selected operands
- apu_flags_o  out  NDSFLAGS  selected flags
- apu_rvalid_i  in  1  APU result valid, results return in issue order
- apu_result_i  in  WIDTH  APU result
- apu_rflags_i  in  NUSFLAGS  APU result flags
- busy_o  out  1  tag FIFO non-empty
- err_o  out  1  sticky protocol error

## Operation
- State:
  - rr_ptr: log2(NCORES) bits, reset 0
  - tag FIFO: MAX_OUTSTANDING x log2(NCORES), with rd/wr pointers and count, reset empty
  - err: reset 0
- Selection: sel = first c with core_req_i[c]=1, scanning rr_ptr, rr_ptr+1, … mod NCORES.
- Issue path:
  - apu_req_o = |core_req_i && count < MAX_OUTSTANDING.
  - apu_op_o, apu_operands_o and apu_flags_o are muxed from sel. When no request is pending they output 0.
- Accept: apu_req_o && apu_gnt_i in the same cycle. On accept:
  - core_gnt_o[sel]=1.
  - Push sel into the tag FIFO.
  - rr_ptr <= (sel+1) mod NCORES.
  - Without an accept, rr_ptr holds.
- Response path:
  - When apu_rvalid_i=1 and count>0: core_rvalid_o[fifo_head]=1 and the head is popped.
  - core_result_o and core_rflags_o always pass apu_result_i and apu_rflags_i through unmodified.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full FIFO: apu_req_o=0 and no grants. There is no same-cycle bypass via a concurrent pop; issue resumes the cycle after count drops.
- Empty FIFO with apu_rvalid_i=1:
  - core_rvalid_o stays all zero, nothing is popped, and err <= 1.
  - This holds even if a push occurs the same cycle; a result never belongs to the op being granted that cycle.
- err_o is sticky until rst.
- Cores keep req, op, operands and flags stable until granted. The arbiter does not register request data.
- Reset mid-operation: all outstanding tags are discarded. APU responses after reset release raise err_o.

## Timing
- Reset values: core_gnt_o=0, core_rvalid_o=0, apu_req_o=0, apu_op_o/operands/flags=0, busy_o=0, err_o=0. core_result_o and core_rflags_o follow their inputs.
- Request to grant: combinational, 0 cycles, when the APU grants and the FIFO is not full.
- rvalid to core_rvalid_o: combinational, 0 cycles; the FIFO head is registered state.
- Minimum accept-to-rvalid for the same op: 1 cycle.
- Throughput: one accept per cycle, one response per cycle, sustained while 0 < count < MAX_OUTSTANDING.
- busy_o is registered from count (count != 0).

## Test plan
- Reset, then core 2 alone requests with apu_gnt_i=1 → core_gnt_o=4'b0100 that cycle; apu_op_o equals core 2 opcode; rr_ptr=3; busy_o=1 next cycle.
- All 4 cores hold requests with apu_gnt_i=1 for 8 cycles → grants go to 0,1,2,3,0,1,2,3 in order. This requires responses (apu_rvalid_i) each cycle starting 1 cycle after the first accept, to avoid the full stall.
- apu_gnt_i=1 and no responses → exactly 4 accepts, then apu_req_o=0 while requests persist. One apu_rvalid_i → rvalid goes to the first-issued core, and issue resumes the next cycle.
- Issue order core 3, core 1, core 3, then 3 responses 2 cycles apart with result 0xDEADBEEF, flags 5'h11 → core_rvalid_o = 1000, 0010, 1000; core_result_o=0xDEADBEEF on each.
- Push and pop in the same cycle at count=2 → count stays 2, correct head routed, no err.
- apu_rvalid_i=1 with an empty FIFO → core_rvalid_o=0, err_o=1 and held. Assert rst mid-stream with 3 outstanding → all outputs at reset values, busy_o=0.
